// File: rtl/rise_delay_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rdm_pkg
//  Description : Shared types and default widths for the rise-delay monitor.
//                rdm_state_e - monitor FSM states (IDLE, WAIT)
//                RDM_CNT_W   - default width of exp_dly and the cycle counter
//                RDM_STAT_W  - default width of the statistic counters
//  Revision    : 1.0 - initial release
// ============================================================================
package rdm_pkg;

    localparam int RDM_CNT_W  = 8;
    localparam int RDM_STAT_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rdm_state_e;

endpackage : rdm_pkg
`default_nettype wire

// File: rtl/rise_delay_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : rise_delay_monitor_if
//  Description : Bundles the monitored a/b pair, configuration and the
//                status/statistics outputs of rise_delay_monitor.
//                master : the environment (drives a_in, b_in, enable,
//                         exp_dly, clr_stats; observes results)
//                slave  : the monitor itself
//                Optional macro RDM_OVERLAP_CNT_EN adds ovl_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rise_delay_monitor_if #(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
);

    logic              enable;
    logic              a_in;
    logic              b_in;
    logic [CNT_W-1:0]  exp_dly;
    logic              clr_stats;
    logic              busy;
    logic              pass_pulse;
    logic              fail_pulse;
    logic [STAT_W-1:0] pass_cnt;
    logic [STAT_W-1:0] fail_cnt;

`ifdef RDM_OVERLAP_CNT_EN
    logic [STAT_W-1:0] ovl_cnt;

    modport master (
        output enable, a_in, b_in, exp_dly, clr_stats,
        input  busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt, ovl_cnt
    );

    modport slave (
        input  enable, a_in, b_in, exp_dly, clr_stats,
        output busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt, ovl_cnt
    );
`else
    modport master (
        output enable, a_in, b_in, exp_dly, clr_stats,
        input  busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt
    );

    modport slave (
        input  enable, a_in, b_in, exp_dly, clr_stats,
        output busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt
    );
`endif

endinterface : rise_delay_monitor_if
`default_nettype wire

// File: rtl/rise_delay_monitor_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : rdm_sat_cnt
//  Description : Saturating up-counter with synchronous clear. Clear wins
//                over increment; the count holds at all-ones.
//                clk, rst (async, active-high), i_inc, i_clr -> o_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module rdm_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic [WIDTH-1:0]      o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : rdm_sat_cnt
`default_nettype wire

// File: rtl/rise_delay_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : rise_delay_monitor
//  Description : Checks that each rising edge of a_in is followed by a rising
//                edge of b_in exactly exp_dly cycles later (the rise of a is
//                cycle 0). Single-thread: rises of a while a check is in
//                flight are dropped. Emits registered pass/fail pulses and
//                saturating pass/fail statistics.
//  Ports       : clk  - clock, posedge sampling
//                rst  - asynchronous active-high reset
//                bus  - rise_delay_monitor_if.slave (enable, a_in, b_in,
//                       exp_dly, clr_stats in; busy, pass_pulse, fail_pulse,
//                       pass_cnt, fail_cnt out)
//  Options     : RDM_OVERLAP_CNT_EN - adds bus.ovl_cnt, a saturating count
//                of rises of a dropped while a check is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_delay_monitor
    import rdm_pkg::*;
#(
    parameter int CNT_W  = RDM_CNT_W,
    parameter int STAT_W = RDM_STAT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rise_delay_monitor_if.slave   bus
);

    rdm_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_dly;
    logic              r_a_q;
    logic              r_b_q;
    logic              r_busy;
    logic              r_pass_pulse;
    logic              r_fail_pulse;

    logic              w_rose_a;
    logic              w_rose_b;
    logic              w_start;
    logic              w_eval;

    // A level already high at the first edge after reset counts as a rise,
    // because the history registers reset to 0.
    assign w_rose_a = bus.a_in & ~r_a_q;
    assign w_rose_b = bus.b_in & ~r_b_q;

    // Zero-delay checks evaluate in the IDLE cycle itself; in WAIT the check
    // fires when the counter reaches the latched delay. A low enable in WAIT
    // aborts, so it also suppresses the evaluation.
    always_comb begin
        w_start = 1'b0;
        w_eval  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = bus.enable & w_rose_a & (bus.exp_dly != '0);
                w_eval  = bus.enable & w_rose_a & (bus.exp_dly == '0);
            end
            WAIT: begin
                w_eval  = bus.enable & (r_cnt == r_dly);
            end
            default: begin
                w_start = 1'b0;
                w_eval  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dly        <= '0;
            r_a_q        <= 1'b0;
            r_b_q        <= 1'b0;
            r_busy       <= 1'b0;
            r_pass_pulse <= 1'b0;
            r_fail_pulse <= 1'b0;
        end else begin
            r_a_q        <= bus.a_in;
            r_b_q        <= bus.b_in;
            r_pass_pulse <= w_eval &  w_rose_b;
            r_fail_pulse <= w_eval & ~w_rose_b;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_dly   <= bus.exp_dly;
                        r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state <= WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    // exp_dly is not looked at here: the latched r_dly rules
                    // the whole check.
                    if (!bus.enable || (r_cnt == r_dly)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.pass_pulse = r_pass_pulse;
    assign bus.fail_pulse = r_fail_pulse;

    // Statistics step on the registered pulse, so a clear in the cycle the
    // pulse is visible discards that pulse from the count.
    rdm_sat_cnt #(
        .WIDTH (STAT_W)
    ) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (r_pass_pulse),
        .i_clr (bus.clr_stats),
        .o_cnt (bus.pass_cnt)
    );

    rdm_sat_cnt #(
        .WIDTH (STAT_W)
    ) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (r_fail_pulse),
        .i_clr (bus.clr_stats),
        .o_cnt (bus.fail_cnt)
    );

`ifdef RDM_OVERLAP_CNT_EN
    // Any rise of a seen while in WAIT is dropped, including the one in the
    // evaluation cycle and one coinciding with an abort.
    logic w_drop;
    assign w_drop = (r_state == WAIT) & w_rose_a;

    rdm_sat_cnt #(
        .WIDTH (STAT_W)
    ) u_ovl_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_drop),
        .i_clr (bus.clr_stats),
        .o_cnt (bus.ovl_cnt)
    );
`endif

endmodule : rise_delay_monitor
`default_nettype wire

// File: tb/tb_rise_delay_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rise_delay_monitor
//  Description : Self-checking bench for rise_delay_monitor. A timestamp
//                based reference model (start time + delay of the in-flight
//                check) predicts busy, pulses and statistics every cycle.
//                Statistics use a narrow width so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rise_delay_monitor;

    localparam int TB_CNT_W  = 8;
    localparam int TB_STAT_W = 6;
    localparam int STAT_MAX  = (1 << TB_STAT_W) - 1;

    logic clk;
    logic rst;

    rise_delay_monitor_if #(.CNT_W(TB_CNT_W), .STAT_W(TB_STAT_W)) u_if ();

    rise_delay_monitor #(
        .CNT_W  (TB_CNT_W),
        .STAT_W (TB_STAT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_t, m_t0, m_d;
    bit m_prev_a, m_prev_b, m_inflight, m_pass_p, m_fail_p;
    int m_pass_cnt, m_fail_cnt, m_ovl_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_t0 = 0; m_d = 0;
        m_prev_a = 0; m_prev_b = 0; m_inflight = 0;
        m_pass_p = 0; m_fail_p = 0;
        m_pass_cnt = 0; m_fail_cnt = 0; m_ovl_cnt = 0;
    endtask

    task automatic model_step(input bit en, input bit a, input bit b, input int dly, input bit clr);
        bit ra, rb, ev;
        m_t++;
        ra = a & ~m_prev_a;
        rb = b & ~m_prev_b;
        m_prev_a = a;
        m_prev_b = b;
        if (clr) begin
            m_pass_cnt = 0;
            m_fail_cnt = 0;
            m_ovl_cnt  = 0;
        end else begin
            if (m_pass_p && m_pass_cnt < STAT_MAX) m_pass_cnt++;
            if (m_fail_p && m_fail_cnt < STAT_MAX) m_fail_cnt++;
            if (m_inflight && ra && m_ovl_cnt < STAT_MAX) m_ovl_cnt++;
        end
        ev = 0;
        if (m_inflight) begin
            if (!en) begin
                m_inflight = 0;
            end else if (m_t - m_t0 == m_d) begin
                ev = 1;
                m_inflight = 0;
            end
        end else if (en && ra) begin
            if (dly == 0) begin
                ev = 1;
            end else begin
                m_inflight = 1;
                m_t0 = m_t;
                m_d  = dly;
            end
        end
        m_pass_p = ev & rb;
        m_fail_p = ev & ~rb;
    endtask

    task automatic check_all();
        check_val("busy",       u_if.busy,       m_inflight);
        check_val("pass_pulse", u_if.pass_pulse, m_pass_p);
        check_val("fail_pulse", u_if.fail_pulse, m_fail_p);
        check_val("pass_cnt",   u_if.pass_cnt,   m_pass_cnt);
        check_val("fail_cnt",   u_if.fail_cnt,   m_fail_cnt);
`ifdef RDM_OVERLAP_CNT_EN
        check_val("ovl_cnt",    u_if.ovl_cnt,    m_ovl_cnt);
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, update model, compare.
    task automatic step(input bit en, input bit a, input bit b, input int dly, input bit clr);
        u_if.enable    = en;
        u_if.a_in      = a;
        u_if.b_in      = b;
        u_if.exp_dly   = dly[TB_CNT_W-1:0];
        u_if.clr_stats = clr;
        @(posedge clk);
        model_step(en, a, b, dly, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        u_if.enable    = 1'b0;
        u_if.a_in      = 1'b0;
        u_if.b_in      = 1'b0;
        u_if.exp_dly   = '0;
        u_if.clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit ra, rb, ren, rclr;
        int rdly;

        do_reset();
        check_all();

        // exp_dly=2: a rises at cycle 2, b at cycle 4 -> pass
        step(1, 0, 0, 2, 0);
        step(1, 1, 0, 2, 0);
        check_val("d1_busy_c3", u_if.busy, 1);
        step(1, 0, 0, 2, 0);
        check_val("d1_busy_c4", u_if.busy, 1);
        step(1, 0, 1, 2, 0);
        check_val("d1_pass", u_if.pass_pulse, 1);
        step(1, 0, 0, 2, 0);
        step(1, 0, 0, 2, 0);
        check_val("d1_pass_cnt", u_if.pass_cnt, 1);

        // exp_dly=2: b one cycle late -> fail, late rise ignored
        step(1, 1, 0, 2, 0);
        step(1, 0, 0, 2, 0);
        step(1, 0, 0, 2, 0);
        check_val("d2_fail", u_if.fail_pulse, 1);
        step(1, 0, 1, 2, 0);
        check_val("d2_late_b", u_if.pass_pulse, 0);
        step(1, 0, 0, 2, 0);
        check_val("d2_fail_cnt", u_if.fail_cnt, 1);

        // exp_dly=0: a and b rise together -> pass, never busy
        step(1, 1, 1, 0, 0);
        check_val("d3_pass", u_if.pass_pulse, 1);
        check_val("d3_busy", u_if.busy, 0);
        step(1, 0, 0, 0, 0);

        // exp_dly=3 with an overlapping rise of a -> exactly one pass
        step(1, 1, 0, 3, 0);
        step(1, 0, 0, 3, 0);
        step(1, 1, 0, 3, 0);
        step(1, 1, 1, 3, 0);
        check_val("d4_pass", u_if.pass_pulse, 1);
        step(1, 0, 0, 3, 0);
        check_val("d4_single", u_if.pass_pulse, 0);
`ifdef RDM_OVERLAP_CNT_EN
        check_val("d4_ovl", u_if.ovl_cnt, 1);
`endif

        // enable low mid-WAIT: abort, no pulse
        step(1, 1, 0, 3, 0);
        step(0, 0, 0, 3, 0);
        step(1, 0, 1, 3, 0);
        step(1, 0, 0, 3, 0);
        check_val("d5_no_pass", u_if.pass_pulse, 0);
        check_val("d5_no_fail", u_if.fail_pulse, 0);

        // saturation of pass_cnt, then clear coinciding with a pulse
        repeat (STAT_MAX + 5) begin
            step(1, 1, 1, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        check_val("sat_hold", u_if.pass_cnt, STAT_MAX);
        step(1, 1, 1, 0, 0);
        check_val("clr_pulse", u_if.pass_pulse, 1);
        step(1, 0, 0, 0, 1);
        check_val("clr_cnt", u_if.pass_cnt, 0);
        step(1, 0, 0, 0, 0);
        check_val("clr_stay", u_if.pass_cnt, 0);

        // asynchronous reset in the middle of a check
        step(1, 1, 0, 4, 0);
        step(1, 1, 0, 4, 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", u_if.busy, 0);
        check_val("arst_pass", u_if.pass_pulse, 0);
        check_val("arst_fail", u_if.fail_pulse, 0);
        check_val("arst_pcnt", u_if.pass_cnt, 0);
        check_val("arst_fcnt", u_if.fail_cnt, 0);
        do_reset();
        check_all();

        // randomized traffic
        ra = 0; rb = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) ra = ~ra;
            if ($urandom_range(0, 1) == 0) rb = ~rb;
            ren  = ($urandom_range(0, 19) != 0);
            rclr = ($urandom_range(0, 59) == 0);
            rdly = $urandom_range(0, 5);
            step(ren, ra, rb, rdly, rclr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rise_delay_monitor
`default_nettype wire

// File: doc/rise_delay_monitor.md
Name: rise_delay_monitor

Overview:
- Synthesizable RTL consumer of an `a`/`b` handshake pair.
- Checks in hardware that every rising edge of `a_in` is followed by a rising edge of `b_in` exactly `exp_dly` clock cycles later, the hardware equivalent of `$rose(a) |-> nexttime[N] $rose(b)`.
- Emits per-check pass/fail pulses and saturating statistics.
- Sits directly downstream of the request/acknowledge generator; feeds status/CSR logic.

Parameters:
- `CNT_W`, 8, width of the expected-delay input and the internal cycle counter.
- `STAT_W`, 16, width of the pass/fail statistic counters.

Ports:
- `clk`  input  1  single clock; all sampling on posedge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  arms monitoring; low forces IDLE.
- `a_in`  input  1  monitored antecedent signal.
- `b_in`  input  1  monitored consequent signal.
- `exp_dly`  input  CNT_W  required cycle distance from rise of `a` to rise of `b`.
- `clr_stats`  input  1  synchronous clear of `pass_cnt`/`fail_cnt`.
- `busy`  output  1  high while a check is in flight (state WAIT).
- `pass_pulse`  output  1  one-cycle pulse per passed check.
- `fail_pulse`  output  1  one-cycle pulse per failed check.
- `pass_cnt`  output  STAT_W  saturating count of passes.
- `fail_cnt`  output  STAT_W  saturating count of failures.

Behaviour:
- Reset (async, `rst`=1): `a_q`=`b_q`=0, state=IDLE, `cnt`=0, `dly_q`=0, `busy`/`pass_pulse`/`fail_pulse`=0, `pass_cnt`/`fail_cnt`=0.
- Edge detect: `rose_a` = `a_in & ~a_q`; `rose_b` = `b_in & ~b_q`.
  - `a_q`/`b_q` register `a_in`/`b_in` every cycle regardless of state.
  - An input already high at the first posedge after reset counts as a rise.
- Cycle of `rose_a` is check cycle 0.
  - Check evaluates only at cycle N=`dly_q`: `rose_b`=1 → pass, else fail.
  - `rose_b` at any other cycle is ignored.
- IDLE:
  - `enable` & `rose_a` & `exp_dly`==0: evaluate same cycle, stay IDLE.
  - `enable` & `rose_a` & `exp_dly`>0: latch `dly_q`=`exp_dly`, `cnt`=1, go to WAIT.
  - Otherwise stay.
- WAIT (`busy`=1):
  - `cnt`==`dly_q`: evaluate, go to IDLE.
  - Else `cnt`++.
  - `exp_dly` changes during WAIT have no effect.
- `rose_a` during WAIT (overlapping antecedent): not checked, no restart. Single-thread monitor.
- A `rose_a` in the same cycle the WAIT check evaluates is also dropped. IDLE is re-entered only on the next cycle.
- `enable` low in WAIT: abort to IDLE next edge, no pulse, no count.
- Outputs registered:
  - `pass_pulse`/`fail_pulse` assert the cycle after the evaluation cycle, for one cycle.
  - Never both high.
- Counters increment with the pulse and saturate at all-ones.
  - `clr_stats` has priority: a pulse coinciding with `clr_stats` is not counted.
  - The pulse itself still appears.

Optional Feature:
- Macro `RDM_OVERLAP_CNT_EN`.
- Defined: adds output `ovl_cnt` [STAT_W], a saturating count of `rose_a` events dropped while in WAIT (including the evaluation-cycle case). Cleared by `rst` and `clr_stats`.
- Undefined: port and logic absent; dropped events are silently ignored.

Decomposition:
- Package `rdm_pkg`:
  - state enum `rdm_state_e` {IDLE, WAIT}.
  - default width constants `RDM_CNT_W`=8 and `RDM_STAT_W`=16.
- Sub-module `rdm_sat_cnt`: parameterized saturating counter with inc/clr, clr priority. Instantiated for pass, fail and optional overlap counts.

Test Plan:
- `exp_dly`=2; `a` rises at cycle 2 and falls at cycle 3; `b` rises at cycle 4 → `pass_pulse` at cycle 5, `pass_cnt`=1, `busy` high cycles 3-4.
- `exp_dly`=2; `a` rises at cycle 2; `b` rises at cycle 5 → `fail_pulse` at cycle 5, `fail_cnt`=1; late `rose_b` ignored.
- `exp_dly`=0; `a` and `b` rise together at cycle 3 → `pass_pulse` at cycle 4, `busy` never asserted.
- `exp_dly`=3; `a` rises at 2, falls at 3, rises again at 4; `b` rises at 5 → one pass only. With `RDM_OVERLAP_CNT_EN`, `ovl_cnt`=1.
- 65540 consecutive passes → `pass_cnt` holds 65535. Then `clr_stats` together with a pass pulse → `pass_cnt`=0.
- `rst` asserted mid-WAIT (async, between edges) → all outputs 0 immediately, state IDLE. `enable` low mid-WAIT → no pulse.
